// File: rtl/pleasure_level.sv
`default_nettype none
// ============================================================================
//  Module      : pleasure_level
//  Description : Saturating pleasure-level accumulator. Consumes inc/dec
//                request levels once per prescaled evaluation tick, moves the
//                level by STEP without wrapping, and exports the level, a
//                2-bit mood code (level MSBs) and saturation flags. With the
//                PLEASURE_DECAY_EN macro defined, the level also drifts one
//                LSB per idle tick toward NEUTRAL after DECAY_IDLE idle ticks.
//  Ports       : clk         - clock, rising edge
//                rst_n       - synchronous active-low reset
//                ena         - freezes prescaler, idle counter and level when low
//                inc / dec   - step requests, sampled on tick cycles
//                level       - registered pleasure level
//                mood        - level[WIDTH-1:WIDTH-2], registered with level
//                sat_hi      - level is at its maximum
//                sat_lo      - level is zero
//                step_strobe - level changed on the previous edge
//  Macro       : PLEASURE_DECAY_EN - enables idle decay toward NEUTRAL
//  Revision    : 1.0 - initial release
// ============================================================================
module pleasure_level #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 16,
    parameter int STEP       = 1,
    parameter int NEUTRAL    = 128,
    parameter int DECAY_IDLE = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       mood,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             step_strobe
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int ICNT_W = $clog2(DECAY_IDLE + 1);
    localparam int WP1    = WIDTH + 1;

    localparam logic [PCNT_W-1:0] c_pcnt_last = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0] c_pcnt_one  = PCNT_W'(1);
    localparam logic [ICNT_W-1:0] c_icnt_max  = ICNT_W'(DECAY_IDLE);
    localparam logic [ICNT_W-1:0] c_icnt_one  = ICNT_W'(1);
    localparam logic [WIDTH-1:0]  c_max       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  c_zero      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  c_neutral   = WIDTH'(NEUTRAL);
    localparam logic [WIDTH:0]    c_step      = WP1'(STEP);

    logic [PCNT_W-1:0] r_pcnt;
    logic [ICNT_W-1:0] r_icnt;

    logic              w_tick;
    logic              w_idle;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH-1:0]  w_inc_level;
    logic [WIDTH-1:0]  w_dec_level;
    logic [WIDTH-1:0]  w_next_level;

    assign w_tick = ena && (r_pcnt == c_pcnt_last);
    // Both requests or neither count as an idle tick.
    assign w_idle = (inc == dec);

    // One extra bit catches overflow; since STEP < 2^WIDTH the carry bit alone
    // tells us the true sum exceeded the maximum.
    assign w_sum       = {1'b0, level} + c_step;
    assign w_inc_level = w_sum[WIDTH] ? c_max : w_sum[WIDTH-1:0];
    assign w_dec_level = ({1'b0, level} < c_step) ? c_zero
                                                  : (level - c_step[WIDTH-1:0]);

`ifdef PLEASURE_DECAY_EN
    logic [WIDTH-1:0] w_decay_level;
    logic             w_decay_go;

    assign w_decay_level = (level > c_neutral) ? (level - WIDTH'(1)) :
                           (level < c_neutral) ? (level + WIDTH'(1)) : level;
    // The idle counter must already be saturated before this tick.
    assign w_decay_go    = w_idle && (r_icnt == c_icnt_max);
`endif

    always_comb begin
        w_next_level = level;
        if (w_tick) begin
            if (inc && !dec) begin
                w_next_level = w_inc_level;
            end else if (dec && !inc) begin
                w_next_level = w_dec_level;
            end
`ifdef PLEASURE_DECAY_EN
            else if (w_decay_go) begin
                w_next_level = w_decay_level;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt      <= '0;
            r_icnt      <= '0;
            level       <= c_neutral;
            mood        <= c_neutral[WIDTH-1:WIDTH-2];
            sat_hi      <= (c_neutral == c_max);
            sat_lo      <= (c_neutral == c_zero);
            step_strobe <= 1'b0;
        end else begin
            if (ena) begin
                r_pcnt <= (r_pcnt == c_pcnt_last) ? '0 : (r_pcnt + c_pcnt_one);
            end

            if (w_tick) begin
                if (!w_idle) begin
                    r_icnt <= '0;
                end else if (r_icnt != c_icnt_max) begin
                    r_icnt <= r_icnt + c_icnt_one;
                end
            end

            // Flags and mood follow the next level so they never lag it.
            level       <= w_next_level;
            mood        <= w_next_level[WIDTH-1:WIDTH-2];
            sat_hi      <= (w_next_level == c_max);
            sat_lo      <= (w_next_level == c_zero);
            step_strobe <= w_tick && (w_next_level != level);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pleasure_level.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pleasure_level
//  Description : Directed self-checking bench for pleasure_level with
//                WIDTH=8, PRESCALE=4, STEP=1, NEUTRAL=128, DECAY_IDLE=3.
//                Expected values follow PLEASURE_DECAY_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pleasure_level;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       inc;
    logic       dec;
    logic [7:0] level;
    logic [1:0] mood;
    logic       sat_hi;
    logic       sat_lo;
    logic       step_strobe;

    int checks = 0;
    int errors = 0;

`ifdef PLEASURE_DECAY_EN
    localparam bit DECAY = 1'b1;
`else
    localparam bit DECAY = 1'b0;
`endif

    pleasure_level #(
        .WIDTH      (8),
        .PRESCALE   (4),
        .STEP       (1),
        .NEUTRAL    (128),
        .DECAY_IDLE (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .inc         (inc),
        .dec         (dec),
        .level       (level),
        .mood        (mood),
        .sat_hi      (sat_hi),
        .sat_lo      (sat_lo),
        .step_strobe (step_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        int start_lvl;
        int exp_lvl;

        rst_n = 1'b0;
        ena   = 1'b1;
        inc   = 1'b0;
        dec   = 1'b0;

        // Reset state
        cyc(2);
        chk("rst_level",  {24'd0, level}, 32'd128);
        chk("rst_mood",   {30'd0, mood}, 32'd2);
        chk("rst_sat_hi", {31'd0, sat_hi}, 32'd0);
        chk("rst_sat_lo", {31'd0, sat_lo}, 32'd0);
        chk("rst_strobe", {31'd0, step_strobe}, 32'd0);

        // Increment held 40 cycles: a tick every 4th edge
        rst_n = 1'b1;
        inc   = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            chk("inc_strobe", {31'd0, step_strobe}, (i % 4 == 0) ? 32'd1 : 32'd0);
            chk("inc_level",  {24'd0, level}, 32'(128 + i / 4));
        end
        chk("inc_final", {24'd0, level}, 32'd138);
        chk("inc_mood",  {30'd0, mood}, 32'd2);

        // ena low freezes everything
        ena = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("ena_level",  {24'd0, level}, 32'd138);
            chk("ena_strobe", {31'd0, step_strobe}, 32'd0);
        end
        ena = 1'b1;
        cyc(3);
        chk("ena_resume_hold", {24'd0, level}, 32'd138);
        cyc(1);
        chk("ena_resume_tick", {24'd0, level}, 32'd139);
        chk("ena_resume_strb", {31'd0, step_strobe}, 32'd1);

        // Reset mid-prescale discards the partial count
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_level",  {24'd0, level}, 32'd128);
        chk("midrst_strobe", {31'd0, step_strobe}, 32'd0);
        rst_n = 1'b1;
        cyc(3);
        chk("midrst_no_tick", {24'd0, level}, 32'd128);
        cyc(1);
        chk("midrst_tick", {24'd0, level}, 32'd129);
        chk("midrst_strb", {31'd0, step_strobe}, 32'd1);

        // Saturation high
        repeat (125) cyc(4);
        chk("sath_pre_level", {24'd0, level}, 32'd254);
        chk("sath_pre_flag",  {31'd0, sat_hi}, 32'd0);
        cyc(4);
        chk("sath_level",  {24'd0, level}, 32'd255);
        chk("sath_flag",   {31'd0, sat_hi}, 32'd1);
        chk("sath_strobe", {31'd0, step_strobe}, 32'd1);
        chk("sath_mood",   {30'd0, mood}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            cyc(4);
            chk("sath_hold_level",  {24'd0, level}, 32'd255);
            chk("sath_hold_strobe", {31'd0, step_strobe}, 32'd0);
        end

        // Saturation low
        inc = 1'b0;
        dec = 1'b1;
        repeat (254) cyc(4);
        chk("satl_pre_level", {24'd0, level}, 32'd1);
        chk("satl_pre_flag",  {31'd0, sat_lo}, 32'd0);
        cyc(4);
        chk("satl_level",  {24'd0, level}, 32'd0);
        chk("satl_flag",   {31'd0, sat_lo}, 32'd1);
        chk("satl_strobe", {31'd0, step_strobe}, 32'd1);
        chk("satl_mood",   {30'd0, mood}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(4);
            chk("satl_hold_level",  {24'd0, level}, 32'd0);
            chk("satl_hold_strobe", {31'd0, step_strobe}, 32'd0);
            chk("satl_hold_sathi",  {31'd0, sat_hi}, 32'd0);
        end

        // Simultaneous requests are idle ticks
        inc = 1'b1;
        dec = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(4);
            exp_lvl = (DECAY && k >= 4) ? (k - 3) : 0;
            chk("both_level",  {24'd0, level}, 32'(exp_lvl));
            chk("both_strobe", {31'd0, step_strobe}, (DECAY && k >= 4) ? 32'd1 : 32'd0);
        end

        // Climb to 131, then go idle
        start_lvl = DECAY ? 2 : 0;
        inc = 1'b1;
        dec = 1'b0;
        repeat (131 - start_lvl) cyc(4);
        chk("decay_pre_level", {24'd0, level}, 32'd131);
        inc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc(4);
            if (!DECAY || k <= 3) exp_lvl = 131;
            else if (k <= 6)      exp_lvl = 131 - (k - 3);
            else                  exp_lvl = 128;
            chk("decay_level",  {24'd0, level}, 32'(exp_lvl));
            chk("decay_strobe", {31'd0, step_strobe},
                (DECAY && k >= 4 && k <= 6) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
